// File: rtl/drac_pkg.sv
// Shared core types: register/address widths, instruction encoding and the
// CPU <-> dcache request/response payloads used by the memory stage.
package drac_pkg;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned ADDR_W = 40;

   typedef logic [REG_W-1:0]  reg_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [XLEN-1:0]   bus64_t;

   typedef enum logic [5:0] {
      NOP,
      LD, LW, LWU, LH, LHU, LB, LBU,
      SD, SW, SH, SB,
      AMO_SWAPW, AMO_ADDW, AMO_SWAPD, AMO_ADDD,
      LR_W, SC_W
   } instr_type_t;

   typedef struct packed {
      logic        valid;
      logic        kill;
      bus64_t      data_rs1;
      bus64_t      data_rs2;
      instr_type_t instr_type;
      logic [2:0]  mem_size;
      reg_t        rd;
      bus64_t      imm;
      addr_t       io_base_addr;
   } req_cpu_dcache_t;

   typedef struct packed {
      logic   ready;
      logic   lock;
      bus64_t data;
      bus64_t addr;
      logic   xcpt_ma_st;
      logic   xcpt_ma_ld;
      logic   xcpt_pf_st;
      logic   xcpt_pf_ld;
   } resp_dcache_cpu_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } dcache_ctrl_state_t;

endpackage

// File: rtl/dcache_req_ctrl.sv
// Memory-stage sequencer: captures one load/store/AMO, issues it to the
// dcache under lock back-pressure, waits for the response and returns it.
module dcache_req_ctrl
   import drac_pkg::*;
#(
   parameter int unsigned RESP_TIMEOUT = 1023
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   input  instr_type_t      instr_type_i,
   input  logic [2:0]       mem_size_i,
   input  reg_t             rd_i,
   input  logic [63:0]      data_rs1_i,
   input  logic [63:0]      data_rs2_i,
   input  logic [63:0]      imm_i,
   input  addr_t            io_base_addr_i,
   input  logic             kill_i,
   input  resp_dcache_cpu_t resp_dcache_i,
   output req_cpu_dcache_t  req_dcache_o,
   output logic             stall_o,
   output logic             done_valid_o,
   output logic [63:0]      done_data_o,
   output reg_t             done_rd_o,
   output logic             done_we_o,
   output logic             xcpt_o,
   output logic             xcpt_ma_o,
   output logic             xcpt_pf_o,
   output logic [63:0]      xcpt_addr_o,
   output logic             timeout_o
);

   localparam int unsigned CNT_W = $clog2(RESP_TIMEOUT + 1);

   dcache_ctrl_state_t state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Latched request fields
   instr_type_t instr_type_q;
   logic [2:0]  mem_size_q;
   reg_t        rd_q;
   logic [63:0] rs1_q, rs2_q, imm_q;
   addr_t       io_base_q;

   // Registered outputs
   logic        req_valid_q, req_valid_d;
   logic        req_kill_q, req_kill_d;
   logic        done_valid_q, done_valid_d;
   logic [63:0] done_data_q, done_data_d;
   reg_t        done_rd_q, done_rd_d;
   logic        done_we_q, done_we_d;
   logic        xcpt_q, xcpt_d;
   logic        ma_q, ma_d;
   logic        pf_q, pf_d;
   logic [63:0] xaddr_q, xaddr_d;
   logic        timeout_q, timeout_d;

   logic capture_c, accept_c, complete_c, expire_c, timeout_c, wait_kill_c;
   logic store_c, resp_ma_c, resp_pf_c, resp_we_c;

   assign capture_c   = (state_q == IDLE) & req_valid_i & ~kill_i;
   assign accept_c    = (state_q == ISSUE) & ~resp_dcache_i.lock;
   assign complete_c  = (state_q == WAIT) & resp_dcache_i.ready;
   assign wait_kill_c = (state_q == WAIT) & kill_i;
   // Counter value entering this cycle's increment is RESP_TIMEOUT-1, so it reaches RESP_TIMEOUT now
   assign expire_c    = ((state_q == ISSUE) | (state_q == WAIT)) &
                        (cnt_q == CNT_W'(RESP_TIMEOUT - 1));
   assign timeout_c   = expire_c & ~kill_i & ~accept_c & ~complete_c;

   assign store_c   = (instr_type_q == SD) | (instr_type_q == SW) |
                      (instr_type_q == SH) | (instr_type_q == SB);
   assign resp_ma_c = resp_dcache_i.xcpt_ma_ld | resp_dcache_i.xcpt_ma_st;
   assign resp_pf_c = resp_dcache_i.xcpt_pf_ld | resp_dcache_i.xcpt_pf_st;
   assign resp_we_c = ~store_c & (rd_q != '0) & ~resp_ma_c & ~resp_pf_c;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; kill beats completion beats timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (capture_c) state_d = ISSUE;
         ISSUE: begin
            if (kill_i)                    state_d = IDLE;
            else if (!resp_dcache_i.lock)  state_d = WAIT;
            else if (expire_c)             state_d = DONE;
         end
         WAIT: begin
            if (kill_i)                    state_d = IDLE;
            else if (resp_dcache_i.ready)  state_d = DONE;
            else if (expire_c)             state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs and the watchdog counter
   always_comb begin
      cnt_d        = cnt_q;
      req_valid_d  = 1'b0;
      req_kill_d   = 1'b0;
      done_valid_d = 1'b0;
      done_data_d  = '0;
      done_rd_d    = '0;
      done_we_d    = 1'b0;
      xcpt_d       = 1'b0;
      ma_d         = 1'b0;
      pf_d         = 1'b0;
      xaddr_d      = '0;
      timeout_d    = 1'b0;

      case (state_q)
         IDLE:        cnt_d = '0;
         ISSUE, WAIT: cnt_d = cnt_q + CNT_W'(1);
         default:     cnt_d = cnt_q;
      endcase

      req_valid_d = (state_d == ISSUE);
      req_kill_d  = wait_kill_c | timeout_c;

      if (complete_c && !kill_i) begin
         done_valid_d = 1'b1;
         done_rd_d    = rd_q;
         done_we_d    = resp_we_c;
         done_data_d  = resp_we_c ? resp_dcache_i.data : 64'd0;
         ma_d         = resp_ma_c;
         pf_d         = resp_pf_c;
         xcpt_d       = resp_ma_c | resp_pf_c;
         xaddr_d      = resp_dcache_i.addr;
      end else if (timeout_c) begin
         done_valid_d = 1'b1;
         done_rd_d    = rd_q;
         timeout_d    = 1'b1;
         xcpt_d       = 1'b1;
         xaddr_d      = rs1_q + imm_q;
      end
   end

   // Request capture
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         instr_type_q <= NOP;
         mem_size_q   <= '0;
         rd_q         <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         imm_q        <= '0;
         io_base_q    <= '0;
      end else if (capture_c) begin
         instr_type_q <= instr_type_i;
         mem_size_q   <= mem_size_i;
         rd_q         <= rd_i;
         rs1_q        <= data_rs1_i;
         rs2_q        <= data_rs2_i;
         imm_q        <= imm_i;
         io_base_q    <= io_base_addr_i;
      end
   end

   // Output and counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q        <= '0;
         req_valid_q  <= 1'b0;
         req_kill_q   <= 1'b0;
         done_valid_q <= 1'b0;
         done_data_q  <= '0;
         done_rd_q    <= '0;
         done_we_q    <= 1'b0;
         xcpt_q       <= 1'b0;
         ma_q         <= 1'b0;
         pf_q         <= 1'b0;
         xaddr_q      <= '0;
         timeout_q    <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         req_valid_q  <= req_valid_d;
         req_kill_q   <= req_kill_d;
         done_valid_q <= done_valid_d;
         done_data_q  <= done_data_d;
         done_rd_q    <= done_rd_d;
         done_we_q    <= done_we_d;
         xcpt_q       <= xcpt_d;
         ma_q         <= ma_d;
         pf_q         <= pf_d;
         xaddr_q      <= xaddr_d;
         timeout_q    <= timeout_d;
      end
   end

   always_comb begin
      req_dcache_o              = '0;
      req_dcache_o.valid        = req_valid_q;
      req_dcache_o.kill         = req_kill_q;
      req_dcache_o.data_rs1     = rs1_q;
      req_dcache_o.data_rs2     = rs2_q;
      req_dcache_o.instr_type   = instr_type_q;
      req_dcache_o.mem_size     = mem_size_q;
      req_dcache_o.rd           = rd_q;
      req_dcache_o.imm          = imm_q;
      req_dcache_o.io_base_addr = io_base_q;
   end

   // A commit kill landing on the result cycle cancels write-back
   assign done_valid_o = done_valid_q & ~kill_i;
   assign done_data_o  = done_data_q;
   assign done_rd_o    = done_rd_q;
   assign done_we_o    = done_we_q;
   assign xcpt_o       = xcpt_q;
   assign xcpt_ma_o    = ma_q;
   assign xcpt_pf_o    = pf_q;
   assign xcpt_addr_o  = xaddr_q;
   assign timeout_o    = timeout_q;

   assign stall_o = (state_q == ISSUE) | (state_q == WAIT) | capture_c;

endmodule

// File: tb/tb_dcache_req_ctrl.sv
// Directed bench for dcache_req_ctrl: inputs change on the falling edge,
// outputs are sampled 1ns later against hand-computed cycle expectations.
module tb_dcache_req_ctrl;
   import drac_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   instr_type_t      instr_type;
   logic [2:0]       mem_size;
   reg_t             rd;
   logic [63:0]      rs1, rs2, imm;
   addr_t            io_base;
   logic             kill;
   resp_dcache_cpu_t resp;
   req_cpu_dcache_t  req;
   logic             stall, done_valid, done_we, xcpt, xcpt_ma, xcpt_pf, timeout;
   logic [63:0]      done_data, xcpt_addr;
   reg_t             done_rd;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dcache_req_ctrl #(.RESP_TIMEOUT(8)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (req_valid),
      .instr_type_i   (instr_type),
      .mem_size_i     (mem_size),
      .rd_i           (rd),
      .data_rs1_i     (rs1),
      .data_rs2_i     (rs2),
      .imm_i          (imm),
      .io_base_addr_i (io_base),
      .kill_i         (kill),
      .resp_dcache_i  (resp),
      .req_dcache_o   (req),
      .stall_o        (stall),
      .done_valid_o   (done_valid),
      .done_data_o    (done_data),
      .done_rd_o      (done_rd),
      .done_we_o      (done_we),
      .xcpt_o         (xcpt),
      .xcpt_ma_o      (xcpt_ma),
      .xcpt_pf_o      (xcpt_pf),
      .xcpt_addr_o    (xcpt_addr),
      .timeout_o      (timeout)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic clear_in();
      req_valid = 1'b0;
      kill      = 1'b0;
      resp      = '0;
   endtask

   task automatic load_req(input instr_type_t t, input reg_t r, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] i);
      req_valid  = 1'b1;
      instr_type = t;
      rd         = r;
      rs1        = a;
      rs2        = b;
      imm        = i;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench watchdog");
   end

   initial begin
      rst        = 1'b1;
      clear_in();
      instr_type = NOP;
      mem_size   = 3'd3;
      rd         = '0;
      rs1        = '0;
      rs2        = '0;
      imm        = '0;
      io_base    = 40'h00_4000_0000;

      // Reset state
      cyc(); rst = 1'b0; #1;
      check_eq("rst_valid", 64'(req.valid), 64'd0);
      check_eq("rst_kill", 64'(req.kill), 64'd0);
      check_eq("rst_rs1", req.data_rs1, 64'd0);
      check_eq("rst_stall", 64'(stall), 64'd0);
      check_eq("rst_done", 64'(done_valid), 64'd0);

      // LD, ready two cycles after acceptance
      cyc(); load_req(LD, 5'd5, 64'h1000, 64'd0, 64'd8); #1;            // C0
      check_eq("ld_c0_stall", 64'(stall), 64'd1);
      check_eq("ld_c0_valid", 64'(req.valid), 64'd0);
      cyc(); req_valid = 1'b0; #1;                                          // C1
      check_eq("ld_c1_valid", 64'(req.valid), 64'd1);
      check_eq("ld_c1_rs1", req.data_rs1, 64'h1000);
      check_eq("ld_c1_imm", req.imm, 64'd8);
      check_eq("ld_c1_rd", 64'(req.rd), 64'd5);
      check_eq("ld_c1_type", 64'(req.instr_type), 64'(LD));
      check_eq("ld_c1_io", 64'(req.io_base_addr), 64'h00_4000_0000);
      check_eq("ld_c1_stall", 64'(stall), 64'd1);
      cyc(); #1;                                                            // C2
      check_eq("ld_c2_valid", 64'(req.valid), 64'd0);
      check_eq("ld_c2_stall", 64'(stall), 64'd1);
      cyc(); resp.ready = 1'b1; resp.data = 64'hDEADBEEF; resp.addr = 64'h1008; #1;  // C3
      check_eq("ld_c3_done", 64'(done_valid), 64'd0);
      check_eq("ld_c3_stall", 64'(stall), 64'd1);
      cyc(); resp = '0; #1;                                                 // C4
      check_eq("ld_c4_done", 64'(done_valid), 64'd1);
      check_eq("ld_c4_data", done_data, 64'hDEADBEEF);
      check_eq("ld_c4_rd", 64'(done_rd), 64'd5);
      check_eq("ld_c4_we", 64'(done_we), 64'd1);
      check_eq("ld_c4_xcpt", 64'(xcpt), 64'd0);
      check_eq("ld_c4_stall", 64'(stall), 64'd0);
      cyc(); #1;
      check_eq("ld_c5_done", 64'(done_valid), 64'd0);

      // SW with lock held four cycles
      cyc(); load_req(SW, 5'd3, 64'h3000, 64'hAA55, 64'd4); #1;          // C0
      cyc(); req_valid = 1'b0; rs2 = 64'hFFFF; resp.lock = 1'b1; #1;      // C1
      check_eq("sw_lock1_valid", 64'(req.valid), 64'd1);
      check_eq("sw_lock1_rs2", req.data_rs2, 64'hAA55);
      for (int i = 2; i <= 4; i++) begin
         cyc(); #1;
         check_eq("sw_lock_valid", 64'(req.valid), 64'd1);
         check_eq("sw_lock_rs2", req.data_rs2, 64'hAA55);
      end
      cyc(); resp.lock = 1'b0; #1;                                          // C5 accepted
      check_eq("sw_acc_valid", 64'(req.valid), 64'd1);
      check_eq("sw_acc_rs2", req.data_rs2, 64'hAA55);
      cyc(); resp.ready = 1'b1; resp.data = 64'h1234; #1;                   // C6
      check_eq("sw_wait_valid", 64'(req.valid), 64'd0);
      cyc(); resp = '0; #1;                                                 // C7
      check_eq("sw_done", 64'(done_valid), 64'd1);
      check_eq("sw_we", 64'(done_we), 64'd0);
      check_eq("sw_data", done_data, 64'd0);
      check_eq("sw_rd", 64'(done_rd), 64'd3);

      // LD killed in its second WAIT cycle, then LW with misaligned-load fault
      cyc(); load_req(LD, 5'd7, 64'h1100, 64'd0, 64'd0);                  // C0
      cyc(); req_valid = 1'b0;                                              // C1
      cyc(); #1;                                                            // C2
      check_eq("kw_c2_valid", 64'(req.valid), 64'd0);
      cyc(); kill = 1'b1; #1;                                               // C3
      check_eq("kw_c3_kill", 64'(req.kill), 64'd0);
      check_eq("kw_c3_stall", 64'(stall), 64'd1);
      cyc(); kill = 1'b0; resp.ready = 1'b1; resp.data = 64'h55;
      load_req(LW, 5'd9, 64'h1000, 64'd0, 64'd3); #1;                     // C4
      check_eq("kw_c4_kill", 64'(req.kill), 64'd1);
      check_eq("kw_c4_valid", 64'(req.valid), 64'd0);
      check_eq("kw_c4_done", 64'(done_valid), 64'd0);
      check_eq("kw_c4_stall", 64'(stall), 64'd1);
      cyc(); req_valid = 1'b0; resp = '0; #1;                               // C5
      check_eq("kw_c5_kill", 64'(req.kill), 64'd0);
      check_eq("kw_c5_valid", 64'(req.valid), 64'd1);
      check_eq("kw_c5_type", 64'(req.instr_type), 64'(LW));
      check_eq("kw_c5_done", 64'(done_valid), 64'd0);
      cyc(); resp.ready = 1'b1; resp.xcpt_ma_ld = 1'b1;
      resp.addr = 64'h1003; resp.data = 64'h77; #1;                          // C6
      cyc(); resp = '0; #1;                                                 // C7
      check_eq("ma_done", 64'(done_valid), 64'd1);
      check_eq("ma_xcpt", 64'(xcpt), 64'd1);
      check_eq("ma_ma", 64'(xcpt_ma), 64'd1);
      check_eq("ma_pf", 64'(xcpt_pf), 64'd0);
      check_eq("ma_addr", xcpt_addr, 64'h1003);
      check_eq("ma_we", 64'(done_we), 64'd0);
      check_eq("ma_data", done_data, 64'd0);
      check_eq("ma_timeout", 64'(timeout), 64'd0);
      check_eq("ma_rd", 64'(done_rd), 64'd9);

      // Watchdog fires (RESP_TIMEOUT=8), fault address wraps at 64 bits
      cyc(); load_req(LD, 5'd4, 64'h4, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8);  // C0
      cyc(); req_valid = 1'b0;                                              // C1
      repeat (6) cyc();                                                     // C2..C7
      cyc(); #1;                                                            // C8
      check_eq("to_c8_done", 64'(done_valid), 64'd0);
      check_eq("to_c8_kill", 64'(req.kill), 64'd0);
      check_eq("to_c8_stall", 64'(stall), 64'd1);
      cyc(); #1;                                                            // C9
      check_eq("to_c9_kill", 64'(req.kill), 64'd1);
      check_eq("to_c9_done", 64'(done_valid), 64'd1);
      check_eq("to_c9_timeout", 64'(timeout), 64'd1);
      check_eq("to_c9_xcpt", 64'(xcpt), 64'd1);
      check_eq("to_c9_ma", 64'(xcpt_ma), 64'd0);
      check_eq("to_c9_addr", xcpt_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      check_eq("to_c9_we", 64'(done_we), 64'd0);
      check_eq("to_c9_valid", 64'(req.valid), 64'd0);
      check_eq("to_c9_stall", 64'(stall), 64'd0);
      cyc(); #1;                                                            // C10
      check_eq("to_c10_kill", 64'(req.kill), 64'd0);
      check_eq("to_c10_done", 64'(done_valid), 64'd0);

      // Ready arrives in the would-be timeout cycle: completion wins
      cyc(); load_req(LD, 5'd4, 64'h4, 64'd0, 64'd8);                     // C0
      cyc(); req_valid = 1'b0;                                              // C1
      repeat (6) cyc();                                                     // C2..C7
      cyc(); resp.ready = 1'b1; resp.data = 64'hCAFE; #1;                   // C8
      check_eq("tr_c8_done", 64'(done_valid), 64'd0);
      cyc(); resp = '0; #1;                                                 // C9
      check_eq("tr_c9_done", 64'(done_valid), 64'd1);
      check_eq("tr_c9_timeout", 64'(timeout), 64'd0);
      check_eq("tr_c9_kill", 64'(req.kill), 64'd0);
      check_eq("tr_c9_xcpt", 64'(xcpt), 64'd0);
      check_eq("tr_c9_we", 64'(done_we), 64'd1);
      check_eq("tr_c9_data", done_data, 64'hCAFE);

      // Minimum latency with kill on the result cycle, then kill blocks capture
      cyc(); load_req(LD, 5'd2, 64'h2000, 64'd0, 64'd0);                  // C0
      cyc(); req_valid = 1'b0;                                              // C1
      cyc(); resp.ready = 1'b1; resp.data = 64'h99;                         // C2
      cyc(); resp = '0; kill = 1'b1; #1;                                    // C3
      check_eq("kd_done", 64'(done_valid), 64'd0);
      check_eq("kd_stall", 64'(stall), 64'd0);
      cyc(); load_req(LD, 5'd2, 64'h2000, 64'd0, 64'd0); #1;              // IDLE, kill held
      check_eq("ki_stall", 64'(stall), 64'd0);
      cyc(); req_valid = 1'b0; kill = 1'b0; #1;
      check_eq("ki_valid", 64'(req.valid), 64'd0);

      // Reset during WAIT
      cyc(); load_req(LD, 5'd6, 64'h5000, 64'd0, 64'd0);                  // C0
      cyc(); req_valid = 1'b0;                                              // C1
      cyc(); rst = 1'b1;                                                    // C2 (WAIT)
      cyc(); rst = 1'b0; resp.ready = 1'b1; resp.data = 64'h42; #1;         // C3
      check_eq("rw_valid", 64'(req.valid), 64'd0);
      check_eq("rw_kill", 64'(req.kill), 64'd0);
      check_eq("rw_rs1", req.data_rs1, 64'd0);
      check_eq("rw_rd", 64'(req.rd), 64'd0);
      check_eq("rw_stall", 64'(stall), 64'd0);
      check_eq("rw_done", 64'(done_valid), 64'd0);
      check_eq("rw_xaddr", xcpt_addr, 64'd0);
      cyc(); resp = '0; #1;                                                 // C4
      check_eq("rw_late_done", 64'(done_valid), 64'd0);
      check_eq("rw_late_kill", 64'(req.kill), 64'd0);
      check_eq("rw_late_stall", 64'(stall), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
